// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one instruction word per PC, keeps it
// toward decode until it is accepted, then loads the externally computed
// next PC and starts the next fetch.
// Optional build macro IFU_ALIGN_CHECK_EN adds a sticky misaligned-PC fault
// (fault port, FAULT state); without it pc[0] goes to memory untouched.
module instr_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] pc,
  input  logic [15:0] pc_next,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] fetch_count
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
    ,
    FAULT = 2'd3
`endif
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic [15:0] fetch_count_q;
  logic        req_d;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fault_q;
`endif

  // Memory request: raised in FETCH/WAIT, suppressed while reset is held so
  // the first post-reset cycle already requests address 0x0000.
  always_comb begin
    req_d = 1'b0;
    if (!reset && (state_q == FETCH || state_q == WAIT)) begin
      req_d = 1'b1;
    end
`ifdef IFU_ALIGN_CHECK_EN
    if (pc_q[0]) begin
      req_d = 1'b0;
    end
`endif
  end

  // Fetch FSM with registered PC, instruction, valid flag and accept counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
`ifdef IFU_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
`ifdef IFU_ALIGN_CHECK_EN
          if (pc_q[0]) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else
`endif
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_q          <= pc_next;
            fetch_count_q <= fetch_count_q + 16'd1;
            valid_q       <= 1'b0;
            state_q       <= FETCH;
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        FAULT: begin
          state_q <= FAULT;
        end
`endif
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // The accept counter is only ever loaded from the FSM above.
  always_comb begin
    count_q = fetch_count_q;
  end

  assign pc          = pc_q;
  assign imem_req    = req_d;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;
`ifdef IFU_ALIGN_CHECK_EN
  assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then randomized traffic. Honours IFU_ALIGN_CHECK_EN like the design.
module tb_instr_fetch_unit;

`ifdef IFU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] fetch_count;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fault;
`endif

  // pc_next source: 0 = pc+2 (emulated PC-control logic), else pcn_val
  int unsigned pcn_mode = 0;
  logic [15:0] pcn_val  = '0;
  assign pc_next = (pcn_mode == 0) ? pc + 16'd2 : pcn_val;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // counter preload handshake for the wrap scenario
  logic        ld_req  = 1'b0;
  logic [15:0] ld_val  = '0;
  logic        cnt_off = 1'b0;

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_count (fetch_count)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fault       (fault)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the unit holds either nothing (and is fetching pc) or
  // one instruction waiting for acceptance; a misaligned pc kills it.
  logic [15:0] m_pc = '0, m_instr = '0, m_count = '0;
  logic        m_valid = 1'b0, m_fault = 1'b0;

  always @(posedge clock) begin
    if (ld_req) m_count = ld_val;
    if (reset) begin
      m_pc = '0; m_instr = '0; m_count = '0; m_valid = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (!m_valid) begin
      if (ALIGN && m_pc[0]) m_fault = 1'b1;
      else if (imem_ack) begin
        m_instr = imem_rdata;
        m_valid = 1'b1;
      end
    end else if (instr_ready) begin
      m_pc    = pc_next;
      m_count = m_count + 16'd1;
      m_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic exp_req;
    exp_req = !reset && !m_valid && !m_fault && !(ALIGN && m_pc[0]);
    chk("m_pc", pc, m_pc);
    chk("m_instr", instr, m_instr);
    chk("m_valid", {15'd0, instr_valid}, {15'd0, m_valid});
    if (!cnt_off) chk("m_count", fetch_count, m_count);
    chk("m_req", {15'd0, imem_req}, {15'd0, exp_req});
    if (exp_req) chk("m_addr", imem_addr, m_pc);
`ifdef IFU_ALIGN_CHECK_EN
    chk("m_fault", {15'd0, fault}, {15'd0, m_fault});
`endif
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
    cyc();
    @(negedge clock);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_count", fetch_count, 16'h0000);
    cyc();
    reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    // A: zero-wait memory, always ready, pc+2
    do_reset();
    pcn_mode = 0; imem_ack = 1'b1; imem_rdata = 16'h1234; instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k % 2 == 0) begin
        chk("A_req", {15'd0, imem_req}, 16'd1);
        chk("A_addr", imem_addr, 16'(k));
      end else begin
        chk("A_valid", {15'd0, instr_valid}, 16'd1);
        chk("A_instr", instr, 16'h1234);
      end
      cyc();
    end

    // B: ack delayed three cycles on the fetch of 0x0002
    do_reset();
    pcn_mode = 0; imem_ack = 1'b1; imem_rdata = 16'hAAAA; instr_ready = 1'b1;
    cyc();
    imem_ack = 1'b0; imem_rdata = 16'hBEEF;
    cyc();
    for (int k = 2; k < 6; k++) begin
      if (k == 5) imem_ack = 1'b1;
      @(negedge clock);
      chk("B_req", {15'd0, imem_req}, 16'd1);
      chk("B_addr", imem_addr, 16'h0002);
      chk("B_instr", instr, 16'hAAAA);
      cyc();
    end
    imem_ack = 1'b0;
    @(negedge clock);
    chk("B_instr_new", instr, 16'hBEEF);
    chk("B_valid_new", {15'd0, instr_valid}, 16'd1);

    // C: decode stalls five cycles, then accepts with pc_next = 0x0040
    do_reset();
    pcn_mode = 1; pcn_val = 16'h0040;
    imem_ack = 1'b1; imem_rdata = 16'h5A5A; instr_ready = 1'b0;
    cyc();
    imem_rdata = 16'hFFFF;
    for (int k = 1; k < 6; k++) begin
      @(negedge clock);
      chk("C_instr", instr, 16'h5A5A);
      chk("C_pc", pc, 16'h0000);
      chk("C_valid", {15'd0, instr_valid}, 16'd1);
      cyc();
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    @(negedge clock);
    chk("C_pc_new", pc, 16'h0040);
    chk("C_count", fetch_count, 16'h0001);

    // D: reset while waiting on memory at pc 0x0010
    do_reset();
    pcn_mode = 0; imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 16'h1111;
    repeat (16) cyc();
    imem_ack = 1'b0;
    cyc();
    @(negedge clock);
    chk("D_pc", pc, 16'h0010);
    chk("D_count", fetch_count, 16'h0008);
    chk("D_addr", imem_addr, 16'h0010);
    cyc();
    reset = 1'b1; imem_ack = 1'b1;
    @(negedge clock);
    chk("D_req_rst", {15'd0, imem_req}, 16'd0);
    cyc();
    reset = 1'b0; imem_ack = 1'b0;
    @(negedge clock);
    chk("D_pc0", pc, 16'h0000);
    chk("D_valid0", {15'd0, instr_valid}, 16'd0);
    chk("D_count0", fetch_count, 16'h0000);
    chk("D_req0", {15'd0, imem_req}, 16'd1);
    chk("D_addr0", imem_addr, 16'h0000);

    // E: accept counter wraps 0xFFFF -> 0x0000
    do_reset();
    pcn_mode = 0; imem_ack = 1'b1; instr_ready = 1'b0; imem_rdata = 16'h7777;
    cyc();
    force dut.fetch_count_q = 16'hFFFE;
    ld_val = 16'hFFFE; ld_req = 1'b1; cnt_off = 1'b1;
    cyc();
    release dut.fetch_count_q;
    ld_req = 1'b0; cnt_off = 1'b0; instr_ready = 1'b1;
    cyc();
    @(negedge clock);
    chk("E_count_ffff", fetch_count, 16'hFFFF);
    cyc();
    cyc();
    @(negedge clock);
    chk("E_count_wrap", fetch_count, 16'h0000);

`ifdef IFU_ALIGN_CHECK_EN
    // G: misaligned next PC is fatal until reset
    do_reset();
    pcn_mode = 1; pcn_val = 16'h0003; imem_ack = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k >= 2) chk("G_req", {15'd0, imem_req}, 16'd0);
      if (k >= 3) begin
        chk("G_fault", {15'd0, fault}, 16'd1);
        chk("G_valid", {15'd0, instr_valid}, 16'd0);
      end
      cyc();
    end
    do_reset();
    @(negedge clock);
    chk("G_fault_clr", {15'd0, fault}, 16'd0);
`endif

    // F: randomized traffic, checked by the model every cycle
    do_reset();
    pcn_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(63) == 0);
      imem_ack    = $urandom_range(1) == 1;
      instr_ready = ($urandom_range(2) != 0);
      imem_rdata  = 16'($urandom);
      pcn_val     = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(15) == 0) pcn_val[0] = 1'b1;
      cyc();
    end

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
